scalar_mult_ctrl: RTL
=====================

# scalar_mult_ctrl

Sequencer that computes a scalar multiple k·P on the twisted-Edwards curve by driving one external point-add/double unit through a left-to-right double-and-add schedule. It sits above the point-add unit and below the top-level protocol FSM. It owns the 255-bit scalar, the base point, the running accumulator and the handshake to the adder. It performs no field arithmetic itself.

## Interface
Parameters:
- COORD_W, 255, width of every projective coordinate.
- SCALAR_W, 255, scalar width; also the bit-counter range.

Ports:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  single-cycle request; accepted only in S_IDLE.
- i_scalar  in  SCALAR_W  scalar k; sampled with i_start.
- i_x, i_y, i_z  in  COORD_W each  base point P in projective coordinates; sampled with i_start.
- o_busy  out  1  high while a multiplication is in progress.
- o_finished  out  1  one-cycle pulse; result valid.
- o_x, o_y, o_z  out  COORD_W each  result k·P; held until the next accepted i_start.
- o_pa_start  out  1  one-cycle start pulse to the point-add unit.
- o_pa_doubling  out  1  1 = doubling (x2/y2/z2 ignored), 0 = general add.
- o_pa_x1, o_pa_y1, o_pa_z1, o_pa_x2, o_pa_y2, o_pa_z2  out  COORD_W each  adder operands.
- i_pa_x3, i_pa_y3, i_pa_z3  in  COORD_W each  adder result.
- i_pa_finished  in  1  adder completion pulse.

## Operation
- Registers:
  - k_r: shifts left; bit k_r[SCALAR_W-1] is the current bit.
  - cnt_r: 8 bits.
  - Base point P_r and accumulator R_r, each three coordinates.
- States: S_IDLE, S_SCAN, S_DBL, S_DBL_WAIT, S_ADD, S_ADD_WAIT, S_NEXT, S_DONE.
- S_IDLE: on i_start, latch k_r, P_r and cnt_r = SCALAR_W-1, then go to S_SCAN.
- S_SCAN: one bit per cycle.
  - If k_r == 0: R_r = (0,1,1) and go to S_DONE.
  - Else if the top bit is 0: shift k_r left, decrement cnt_r, stay.
  - Else: R_r = P_r and shift k_r left.
    - If cnt_r == 0, go to S_DONE.
    - Otherwise go to S_DBL.
- S_DBL: pulse o_pa_start with o_pa_doubling = 1, operands x1 = x2 = R_r; go to S_DBL_WAIT.
- S_DBL_WAIT: on i_pa_finished, R_r = i_pa_x3/y3/z3. Then go to S_ADD if the current bit is 1, else to S_NEXT.
- S_ADD: pulse o_pa_start with o_pa_doubling = 0, operand 1 = R_r, operand 2 = P_r; go to S_ADD_WAIT.
- S_ADD_WAIT: on i_pa_finished, R_r = result; go to S_NEXT.
- S_NEXT: shift k_r left and decrement cnt_r.
  - If the new cnt_r == 0, go to S_DONE.
  - Else go to S_DBL.
- S_DONE: o_x/o_y/o_z = R_r; pulse o_finished; return to S_IDLE.
- i_start outside S_IDLE is ignored.
- i_pa_finished outside the two WAIT states is ignored.
- The operand outputs hold stable from the o_pa_start pulse until i_pa_finished.

## Timing
- Reset values: every output is 0, the state is S_IDLE and all registers are 0.
- Reset mid-operation aborts immediately; the point-add unit shares i_rst.
- o_busy rises the cycle after i_start is accepted. It falls in the same cycle o_finished pulses.
- o_pa_start is registered: it is high for exactly one cycle, the cycle after S_DBL or S_ADD is entered.
- Latency, non-CT mode, for MSB position m and popcount w:
  - Scan: (SCALAR_W-1-m) + 1 cycles.
  - Processing: m doublings plus (w-1) adds, each costing 2 cycles plus the adder latency.
  - Each processed bit also costs one S_NEXT cycle.
  - Finish: 1 cycle.
- Scalar 0 completes after 1 scan cycle plus 1 S_DONE cycle.

## Configuration
- SCALAR_MULT_CONST_TIME_EN:
  - S_SCAN is skipped. R_r starts at (0,1,1) and cnt_r = SCALAR_W.
  - Every bit performs both a double and an add. The add result is written to R_r only when the bit is 1 and is otherwise discarded.
  - Latency is independent of k: 255 doubles and 255 adds.
- Undefined: leading-zero skip and conditional add, as described above.

## Test plan
Use a behavioural point-add stub with a fixed 20-cycle latency and an operation log.
- k=0 → o_x/o_y/o_z = (0,1,1); zero o_pa_start pulses; o_finished 2 cycles after start.
- k=1, P=(5,7,1) → result (5,7,1); zero adder transactions; 255 scan cycles before S_DONE.
- k=3 → log shows [DBL(P), ADD(2P,P)]; result equals the stub's model of 3P.
- k=2^254+1 → 254 DBL then 1 ADD; o_busy stays high throughout; i_start pulsed mid-run is ignored.
- Assert i_rst during the 3rd S_DBL_WAIT of k=0xFF → all outputs 0 on the next edge. A fresh start with k=2 then completes correctly.
- With SCALAR_MULT_CONST_TIME_EN, k=0 and k=2^255-1 → both runs issue exactly 510 transactions; identical latency; k=0 yields (0,1,1).

Source files
------------

// File: rtl/scalar_mult_ctrl_if.sv
// Host request/result and point-add handshake bundle for scalar_mult_ctrl.
// slave = controller view, master = host/adder environment view.
interface scalar_mult_ctrl_if #(
  parameter int unsigned COORD_W  = 255,
  parameter int unsigned SCALAR_W = 255
);
  logic                i_start;
  logic [SCALAR_W-1:0] i_scalar;
  logic [COORD_W-1:0]  i_x, i_y, i_z;
  logic                o_busy;
  logic                o_finished;
  logic [COORD_W-1:0]  o_x, o_y, o_z;
  logic                o_pa_start;
  logic                o_pa_doubling;
  logic [COORD_W-1:0]  o_pa_x1, o_pa_y1, o_pa_z1;
  logic [COORD_W-1:0]  o_pa_x2, o_pa_y2, o_pa_z2;
  logic [COORD_W-1:0]  i_pa_x3, i_pa_y3, i_pa_z3;
  logic                i_pa_finished;

  modport slave (
    input  i_start, i_scalar, i_x, i_y, i_z,
    output o_busy, o_finished, o_x, o_y, o_z,
    output o_pa_start, o_pa_doubling,
    output o_pa_x1, o_pa_y1, o_pa_z1, o_pa_x2, o_pa_y2, o_pa_z2,
    input  i_pa_x3, i_pa_y3, i_pa_z3, i_pa_finished
  );

  modport master (
    output i_start, i_scalar, i_x, i_y, i_z,
    input  o_busy, o_finished, o_x, o_y, o_z,
    input  o_pa_start, o_pa_doubling,
    input  o_pa_x1, o_pa_y1, o_pa_z1, o_pa_x2, o_pa_y2, o_pa_z2,
    output i_pa_x3, i_pa_y3, i_pa_z3, i_pa_finished
  );
endinterface

// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer driving an external point-add unit.
// Define SCALAR_MULT_CONST_TIME_EN for the fixed-schedule (always double+add) variant.
module scalar_mult_ctrl #(
  parameter int unsigned COORD_W  = 255,
  parameter int unsigned SCALAR_W = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  scalar_mult_ctrl_if.slave  bus
);
  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } point_t;

  localparam point_t IDENT = '{x: '0, y: COORD_W'(1), z: COORD_W'(1)};

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_DBL, S_DBL_WAIT, S_ADD, S_ADD_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [SCALAR_W-1:0] k_q, k_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  point_t              p_q, p_d, r_q, r_d, res_q, res_d, op1_q, op1_d, op2_q, op2_d;
  logic                busy_q, busy_d, fin_q, fin_d, pa_start_q, pa_start_d, pa_dbl_q, pa_dbl_d;
  point_t              pa_res;

  assign pa_res = '{x: bus.i_pa_x3, y: bus.i_pa_y3, z: bus.i_pa_z3};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      cnt_q      <= '0;
      p_q        <= '0;
      r_q        <= '0;
      res_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      busy_q     <= 1'b0;
      fin_q      <= 1'b0;
      pa_start_q <= 1'b0;
      pa_dbl_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      r_q        <= r_d;
      res_q      <= res_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      busy_q     <= busy_d;
      fin_q      <= fin_d;
      pa_start_q <= pa_start_d;
      pa_dbl_q   <= pa_dbl_d;
    end
  end

  // k_q[MSB] is the bit being processed; it is shifted out in S_SCAN/S_NEXT.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    r_d        = r_q;
    res_d      = res_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    busy_d     = busy_q;
    fin_d      = 1'b0;
    pa_start_d = 1'b0;
    pa_dbl_d   = pa_dbl_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          k_d    = bus.i_scalar;
          p_d    = '{x: bus.i_x, y: bus.i_y, z: bus.i_z};
          busy_d = 1'b1;
`ifdef SCALAR_MULT_CONST_TIME_EN
          r_d     = IDENT;
          cnt_d   = CNT_W'(SCALAR_W);
          state_d = S_DBL;
`else
          cnt_d   = CNT_W'(SCALAR_W - 1);
          state_d = S_SCAN;
`endif
        end
      end
`ifndef SCALAR_MULT_CONST_TIME_EN
      S_SCAN: begin
        if (k_q == '0) begin
          r_d     = IDENT;
          state_d = S_DONE;
        end else if (!k_q[SCALAR_W-1]) begin
          k_d   = k_q << 1;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          r_d     = p_q;
          k_d     = k_q << 1;
          state_d = (cnt_q == '0) ? S_DONE : S_DBL;
        end
      end
`endif
      S_DBL: begin
        pa_start_d = 1'b1;
        pa_dbl_d   = 1'b1;
        op1_d      = r_q;
        op2_d      = r_q;
        state_d    = S_DBL_WAIT;
      end
      S_DBL_WAIT: begin
        if (bus.i_pa_finished) begin
          r_d = pa_res;
`ifdef SCALAR_MULT_CONST_TIME_EN
          state_d = S_ADD;
`else
          state_d = k_q[SCALAR_W-1] ? S_ADD : S_NEXT;
`endif
        end
      end
      S_ADD: begin
        pa_start_d = 1'b1;
        pa_dbl_d   = 1'b0;
        op1_d      = r_q;
        op2_d      = p_q;
        state_d    = S_ADD_WAIT;
      end
      S_ADD_WAIT: begin
        if (bus.i_pa_finished) begin
`ifdef SCALAR_MULT_CONST_TIME_EN
          if (k_q[SCALAR_W-1]) r_d = pa_res;
`else
          r_d = pa_res;
`endif
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        k_d     = k_q << 1;
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = (cnt_q == CNT_W'(1)) ? S_DONE : S_DBL;
      end
      S_DONE: begin
        res_d   = r_q;
        fin_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_busy        = busy_q;
  assign bus.o_finished    = fin_q;
  assign bus.o_x           = res_q.x;
  assign bus.o_y           = res_q.y;
  assign bus.o_z           = res_q.z;
  assign bus.o_pa_start    = pa_start_q;
  assign bus.o_pa_doubling = pa_dbl_q;
  assign bus.o_pa_x1       = op1_q.x;
  assign bus.o_pa_y1       = op1_q.y;
  assign bus.o_pa_z1       = op1_q.z;
  assign bus.o_pa_x2       = op2_q.x;
  assign bus.o_pa_y2       = op2_q.y;
  assign bus.o_pa_z2       = op2_q.z;
endmodule
